// File: rtl/stream_match_checker.sv
// Word-stream checker: compares expected/actual pairs over valid/ready for a programmed run length.
// Optional build macro STREAM_CHECKER_STOP_ON_ERR_EN ends the run on the first mismatch.
module stream_match_checker #(
    parameter int LENGTH = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] exp_data,
    input  logic [LENGTH-1:0] act_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              first_err_valid
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic             fvld_q, fvld_d;
    logic             pass_q, pass_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             xfer, word_match, last_word, stop_now;

    function automatic logic words_match(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b);
        return &(a ~^ b);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        idx_d      = idx_q;
        err_d      = err_q;
        fidx_d     = fidx_q;
        fvld_d     = fvld_q;
        pass_d     = pass_q;
        xfer       = (state_q == RUN) && in_valid;
        word_match = words_match(exp_data, act_data);
        last_word  = (idx_q == num_q - ONE);
`ifdef STREAM_CHECKER_STOP_ON_ERR_EN
        stop_now   = xfer && !word_match;
`else
        stop_now   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_words;
                    idx_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fvld_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = (num_words == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    idx_d = idx_q + ONE;
                    if (!word_match) begin
                        err_d = sat_inc(err_q);
                        if (!fvld_q) begin
                            fidx_d = idx_q;
                            fvld_d = 1'b1;
                        end
                    end
                    if (last_word || stop_now) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Verdict is registered on entry to FIN so it is visible alongside done.
        if (state_q != FIN && state_d == FIN) pass_d = (err_d == '0);
        rdy_d  = (state_d == RUN);
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fvld_q  <= 1'b0;
            pass_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fvld_q  <= fvld_d;
            pass_q  <= pass_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready        = rdy_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fvld_q;

endmodule

// File: doc/stream_match_checker.md
# stream_match_checker

Sequential word-stream checker built around the team's bitwise equality compare. It accepts pairs of expected and actual words over a valid/ready handshake for a programmed number of words. It counts mismatches, records the index of the first mismatch, and reports pass/fail when the run ends. It sits at the consuming end of a data path under test, between a pattern source and the status/debug registers.

## Interface
- LENGTH, 8, word width in bits.
- CNT_W, 16, width of the word count, error count and index.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- num_words  input  CNT_W  words in the run; latched on accepted start.
- in_valid  input  1  expected/actual pair present.
- in_ready  output  1  checker can accept a pair.
- exp_data  input  LENGTH  expected word.
- act_data  input  LENGTH  actual word.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  last run had zero mismatches; valid from done until next start.
- err_count  output  CNT_W  mismatch count, saturating.
- first_err_idx  output  CNT_W  0-based index of first mismatching word.
- first_err_valid  output  1  first_err_idx holds a captured index.

## Operation
- Clock and reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Compare rule: a word matches when every bit satisfies exp_data[i] == act_data[i]. Implement it as the AND-reduction of a per-bit XNOR.
- FSM states:
  - IDLE: in_ready=0, busy=0. On start=1, latch num_words, clear err_count, first_err_idx and first_err_valid, and clear pass. Go to RUN, or to FIN if num_words==0.
  - RUN: in_ready=1, busy=1. Each cycle with in_valid=1 is a transfer: compare, then increment word index idx (CNT_W bits). On the transfer where idx==num_words-1, go to FIN.
  - FIN: busy=0, in_ready=0. Assert done for this one cycle, set pass=(err_count==0), and return to IDLE.
- Mismatch on a transfer: err_count increments and holds at 2^CNT_W-1 (saturating). If first_err_valid==0, capture first_err_idx=idx and set first_err_valid=1.
- Input is ignored (no transfer) in IDLE and FIN. start is ignored outside IDLE.
- Results (pass, err_count, first_err_idx, first_err_valid) hold after the run until the next accepted start or rst.
- Reset at any time, including mid-run, drives everything to IDLE values immediately. The aborted run produces no done.

## Timing
- Reset values: in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, FSM in IDLE.
- Start accepted at edge N: busy=1 and in_ready=1 from cycle N+1.
- Last transfer at edge M: from cycle M+1, done=1 and pass is valid for that single cycle, with busy=0 and in_ready=0. IDLE is reached at M+2, so a new start is accepted no earlier than cycle M+2.
- err_count and first_err_* update the cycle after the offending transfer.
- Throughput: one pair per cycle while in_valid stays high. Bubbles (in_valid=0) stall with no state change.
- num_words==0: done is asserted in cycle N+1, pass=1, err_count=0.

## Configuration
- STREAM_CHECKER_STOP_ON_ERR_EN defined:
  - The first mismatching transfer moves the FSM to FIN instead of continuing.
  - done pulses the cycle after that transfer, with pass=0, err_count=1, and first_err_idx equal to that index.
  - Remaining words are never accepted.
- Not defined: the run always consumes exactly num_words transfers, regardless of mismatches.

## Test plan
- Reset mid-run: start with num_words=4 and issue 2 transfers, then pulse rst. All outputs return to reset values and no done occurs. A new run with num_words=1 and a matching pair gives done with pass=1.
- All match: LENGTH=8, num_words=3, pairs (0x6F,0x6F), (0x00,0x00), (0xFF,0xFF) back-to-back. done is asserted the cycle after the third transfer, pass=1, err_count=0, first_err_valid=0.
- Mismatches: num_words=4, pairs (0x6F,0x6F), (0x6F,0x6C), (0x11,0x11), (0x80,0x00). pass=0, err_count=2, first_err_idx=1, first_err_valid=1. With STREAM_CHECKER_STOP_ON_ERR_EN: done after transfer 1, err_count=1, and the 3rd/4th pairs see in_ready=0.
- Handshake stalls: num_words=2 with in_valid toggling 1,0,0,1. Exactly 2 transfers occur and done is asserted the cycle after the 4th cycle. start pulsed during RUN has no effect.
- Zero-length run: start with num_words=0. done is asserted the next cycle, pass=1, and in_ready is never 1.
- Saturation: CNT_W=4, num_words=15 with a mismatch on every pair. err_count=15 (not wrapping to 0) and first_err_idx=0.
